// File: rtl/grid_plotter.sv
// grid_plotter: cursor-driven cell rasteriser for the game board's VGA adapter.
// Each accepted advance sweeps one CELL_W x CELL_H rectangle, then steps the cursor.
//
// state | meaning
// IDLE  | waiting for advance; X/Y show the cursor cell's top-left pixel
// DRAW  | sweeping the cell one pixel per cycle in raster order
module grid_plotter #(
    parameter int X0        = 20,
    parameter int Y0        = 30,
    parameter int COL_PITCH = 10,
    parameter int ROW_PITCH = 4,
    parameter int ROWS      = 5,
    parameter int COLS      = 8,
    parameter int CELL_W    = 8,
    parameter int CELL_H    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
    input  logic       correct,
    input  logic [1:0] selection,
    output logic [7:0] X,
    output logic [7:0] Y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       grid_full
);
    localparam int RW  = $clog2(ROWS);
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DXW = $clog2(CELL_W);
    localparam int DYW = $clog2(CELL_H);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t         state, state_next;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;
    logic [1:0]     mode;
    logic           corr;
    logic           full;
    logic           accept;
    logic           dx_last, dy_last, last_px;
    logic           on_edge;
    logic [2:0]     mode_colour;
    logic [7:0]     x_pix, y_pix;

    // full is the internal flag so a request racing the final done is refused
    assign accept  = (state == IDLE) && advance && !full;
    assign dx_last = (dx == DXW'(CELL_W - 1));
    assign dy_last = (dy == DYW'(CELL_H - 1));
    assign last_px = dx_last && dy_last;
    assign on_edge = (dx == '0) || dx_last || (dy == '0) || dy_last;

    // dx/dy rest at zero in IDLE, so the same sum yields the cell's top-left pixel
    assign x_pix = 8'(X0 + int'(col) * COL_PITCH + int'(dx));
    assign y_pix = 8'(Y0 + int'(row) * ROW_PITCH + int'(dy));

    always_comb begin
        mode_colour = 3'b111;
        case (mode)
            2'b00:   mode_colour = 3'b100;
            2'b10:   mode_colour = 3'b000;
            default: mode_colour = 3'b111;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)  state_next = DRAW;
            DRAW:    if (last_px) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row  <= '0;
            col  <= '0;
            dx   <= '0;
            dy   <= '0;
            mode <= 2'b00;
            corr <= 1'b0;
            full <= 1'b0;
        end else if (accept) begin
            mode <= selection;
            corr <= correct;
            dx   <= '0;
            dy   <= '0;
        end else if (state == DRAW) begin
            if (!dx_last) begin
                dx <= dx + DXW'(1);
            end else begin
                dx <= '0;
                if (!dy_last) begin
                    dy <= dy + DYW'(1);
                end else begin
                    dy <= '0;
                    if (!corr) begin
                        row <= '0;
                    end else if (row != RW'(ROWS - 1)) begin
                        row <= row + RW'(1);
                    end else if (col != CW'(COLS - 1)) begin
                        row <= '0;
                        col <= col + CW'(1);
                    end else begin
                        full <= 1'b1;
                    end
                end
            end
        end
    end

    // Output stage lags the sweep counters by one edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            X         <= 8'(X0);
            Y         <= 8'(Y0);
            colour    <= 3'b000;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            grid_full <= 1'b0;
        end else begin
            X         <= x_pix;
            Y         <= y_pix;
            busy      <= (state == DRAW);
            done      <= (state == IDLE) && busy;
            plot      <= (state == DRAW) && ((mode != 2'b11) || on_edge);
            grid_full <= full;
            if (state == DRAW) colour <= mode_colour;
        end
    end
endmodule

// File: tb/tb_grid_plotter.sv
// Self-checking bench for grid_plotter: expected pixels are queued when an advance
// is driven and popped by a monitor on every plot strobe.
module tb_grid_plotter;
    logic       clock;
    logic       reset;
    logic       advance;
    logic       correct;
    logic [1:0] selection;
    logic [7:0] X;
    logic [7:0] Y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       grid_full;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   plot_cnt   = 0;
    int   m_row      = 0;
    int   m_col      = 0;
    bit   m_full     = 0;

    grid_plotter dut (
        .clock     (clock),
        .reset     (reset),
        .advance   (advance),
        .correct   (correct),
        .selection (selection),
        .X         (X),
        .Y         (Y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done),
        .grid_full (grid_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_cell(input logic [1:0] sel);
        pix_t       p;
        logic [2:0] c;
        c = (sel == 2'b00) ? 3'b100 : (sel == 2'b10) ? 3'b000 : 3'b111;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 8; dx++)
                if (sel != 2'b11 || dx == 0 || dx == 7 || dy == 0 || dy == 2) begin
                    p.x = 8'(20 + m_col * 10 + dx);
                    p.y = 8'(30 + m_row * 4 + dy);
                    p.c = c;
                    exp_q.push_back(p);
                end
    endfunction

    function automatic void model_step(input logic cor);
        if (!cor)             m_row = 0;
        else if (m_row < 4)   m_row++;
        else if (m_col < 7) begin
            m_row = 0;
            m_col++;
        end else              m_full = 1;
    endfunction

    function automatic void model_reset();
        m_row  = 0;
        m_col  = 0;
        m_full = 0;
        exp_q.delete();
    endfunction

    always @(negedge clock) begin
        if (reset && plot) begin
            plot_cnt++;
            compared++;
            assert (exp_q.size() > 0)
            else begin
                mismatched++;
                $error("FAIL unexpected_plot: observed plot at (%0d,%0d) expected none", X, Y);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("pixel_xyc", {13'b0, X, Y, colour}, {13'b0, mon_e});
            end
        end
    end

    // Entered at the negedge right after the acceptance edge; returns at the done cycle.
    task automatic follow_sweep(input logic [1:0] sel, input logic cor, input bit hold);
        int n_exp;
        n_exp    = (sel == 2'b11) ? 18 : 24;
        plot_cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            check("busy_in_sweep", 32'(busy), 32'd1);
            check("done_in_sweep", 32'(done), 32'd0);
            if (k < 24) begin
                selection = 2'($urandom_range(0, 3));
                correct   = 1'($urandom_range(0, 1));
            end else begin
                selection = sel;
                correct   = cor;
            end
            if (k == 10 && !hold) advance = 1'b0;
        end
        @(negedge clock);
        model_step(cor);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("plot_after", 32'(plot), 32'd0);
        check("plot_count", 32'(plot_cnt), 32'(n_exp));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("cursor_x", 32'(X), 32'(20 + m_col * 10));
        check("cursor_y", 32'(Y), 32'(30 + m_row * 4));
        check("grid_full", 32'(grid_full), 32'(m_full));
    endtask

    task automatic sweep(input logic [1:0] sel, input logic cor);
        @(negedge clock);
        advance   = 1'b1;
        selection = sel;
        correct   = cor;
        push_cell(sel);
        @(negedge clock);
        advance   = 1'b0;
        follow_sweep(sel, cor, 1'b0);
    endtask

    initial begin
        advance   = 1'b0;
        correct   = 1'b0;
        selection = 2'b00;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        #1;
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_full", 32'(grid_full), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_x", 32'(X), 32'd20);
        check("rst_y", 32'(Y), 32'd30);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Abandon a sweep after its third pixel
        @(negedge clock);
        advance   = 1'b1;
        selection = 2'b00;
        correct   = 1'b1;
        push_cell(2'b00);
        @(negedge clock);
        advance = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("midrst_plot", 32'(plot), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_x", 32'(X), 32'd20);
        check("midrst_y", 32'(Y), 32'd30);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_plot", 32'(plot), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_x", 32'(X), 32'd20);
        check("post_rst_y", 32'(Y), 32'd30);

        // Filled, outline, then wrap into column 1
        sweep(2'b00, 1'b1);
        check("row1_y", 32'(Y), 32'd34);
        sweep(2'b11, 1'b1);
        sweep(2'b01, 1'b1);
        sweep(2'b00, 1'b1);
        sweep(2'b01, 1'b1);
        check("col1_x", 32'(X), 32'd30);
        check("col1_y", 32'(Y), 32'd30);
        sweep(2'b01, 1'b1);
        sweep(2'b10, 1'b0);
        check("erase_x", 32'(X), 32'd30);
        check("erase_y", 32'(Y), 32'd30);

        // Fill the whole grid
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) sweep(2'($urandom_range(0, 3)), 1'b1);
        check("grid_full_set", 32'(grid_full), 32'd1);
        @(negedge clock);
        advance   = 1'b1;
        selection = 2'b00;
        correct   = 1'b1;
        @(negedge clock);
        advance = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            check("full_no_busy", 32'(busy), 32'd0);
            check("full_no_plot", 32'(plot), 32'd0);
        end
        check("full_sticky", 32'(grid_full), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check("full_cleared", 32'(grid_full), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // advance held high: back-to-back sweeps every 25 cycles
        @(negedge clock);
        advance   = 1'b1;
        selection = 2'b01;
        correct   = 1'b1;
        push_cell(2'b01);
        @(negedge clock);
        follow_sweep(2'b01, 1'b1, 1'b1);
        push_cell(2'b01);
        follow_sweep(2'b01, 1'b1, 1'b1);
        push_cell(2'b01);
        follow_sweep(2'b01, 1'b1, 1'b0);
        @(negedge clock);
        check("held_done_width", 32'(done), 32'd0);
        check("held_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
